// File: rtl/s2pc_pkg.sv
// Shared types and helpers for the s2pc_stream serial-to-parallel converter.
package s2pc_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Zero padding above the word does not change the XOR reduction.
  function automatic logic parity(input logic [63:0] word, input logic odd);
    return odd ? ~^word : ^word;
  endfunction

endpackage

// File: rtl/s2pc_shift_core.sv
// Shift register and bit counter; assembles one word in either bit order.
module s2pc_shift_core
  import s2pc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             accept_i,
  input  logic             bit_i,
  input  logic             slot_free_i,
  input  logic             release_i,
  output logic [WIDTH-1:0] word_o,
  output logic [WIDTH-1:0] next_word_o,
  output logic             last_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    if (MSB_FIRST != 0) begin
      next_word_o = {sr_q[WIDTH-2:0], bit_i};
    end else begin
      next_word_o = {bit_i, sr_q[WIDTH-1:1]};
    end
  end

  assign last_o  = accept_i && (cnt_q == CW'(WIDTH - 1));
  assign full_o  = (cnt_q == CW'(WIDTH));
  assign word_o  = sr_q;
  assign count_o = cnt_q;

  // A completed word that cannot leave parks here with the count pinned at WIDTH.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept_i) begin
      sr_d = next_word_o;
      if (last_o) begin
        cnt_d = slot_free_i ? '0 : CW'(WIDTH);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (release_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/s2pc_stream.sv
// Serial-to-parallel converter with parity and a one-word output slot
// behind a valid/ready handshake.
module s2pc_stream
  import s2pc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_ODD = PAR_EVEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       s_valid,
  input  logic                       s_in,
  output logic                       s_ready,
  output logic [WIDTH:0]             par_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int   CW  = $clog2(WIDTH + 1);
  localparam logic ODD = (PARITY_ODD != PAR_EVEN);

  state_e           state_q;
  logic [WIDTH:0]   par_q;
  logic             ov_q;
  logic             accept;
  logic             take;
  logic             slot_free;
  logic             release_w;
  logic             last;
  logic             full;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] next_word;

  assign s_ready   = (state_q == COLLECT) && !rst;
  assign accept    = s_valid && s_ready && !clear;
  assign take      = ov_q && out_ready;
  assign slot_free = !ov_q || out_ready;
  assign release_w = (state_q == HOLD) && take && full;

  s2pc_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .CW       (CW)
  ) u_core (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .accept_i   (accept),
    .bit_i      (s_in),
    .slot_free_i(slot_free),
    .release_i  (release_w),
    .word_o     (word),
    .next_word_o(next_word),
    .last_o     (last),
    .full_o     (full),
    .count_o    (bit_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      par_q   <= '0;
      ov_q    <= 1'b0;
    end else if (clear) begin
      state_q <= COLLECT;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (last && slot_free) begin
            par_q <= {parity(64'(next_word), ODD), next_word};
            ov_q  <= 1'b1;
          end else if (last) begin
            state_q <= HOLD;
          end else if (take) begin
            ov_q <= 1'b0;
          end
        end
        HOLD: begin
          // Swap the parked word into the slot as the old one leaves.
          if (release_w) begin
            par_q   <= {parity(64'(word), ODD), word};
            ov_q    <= 1'b1;
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign par_out   = par_q;
  assign out_valid = ov_q;

endmodule
